// File: rtl/jtag_dtm_tap.sv
// jtag_dtm_tap: oversampled JTAG TAP controller and RISC-V DTM bridging DMI scans to a valid/ready debug-module port
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1e200a6d,
    parameter int          DMI_ABITS    = 6,
    parameter int          IDLE_HINT    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   jtag_TCK,
    input  logic                   jtag_TMS,
    input  logic                   jtag_TDI,
    output logic                   jtag_TDO,
    output logic                   dtm_req_valid_o,
    input  logic                   dtm_req_ready_i,
    output logic [DMI_ABITS+33:0]  dtm_req_data_o,
    input  logic                   dm_resp_valid_i,
    output logic                   dm_resp_ready_o,
    input  logic [DMI_ABITS+33:0]  dm_resp_data_i
);
    localparam int DW = DMI_ABITS + 34;
    localparam logic [2:0] IDLE_F  = 3'(IDLE_HINT);
    localparam logic [5:0] ABITS_F = 6'(DMI_ABITS);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    tap_e            state, tap_next;
    logic [2:0]      tck_s;
    logic [1:0]      tms_s, tdi_s;
    logic            tck_rise, tck_fall, tms, tdi;
    logic [4:0]      ir, ir_sh;
    logic [DW-1:0]   dr_sh, dr_cap, dr_shift, resp_q, resp_now, dmi_cap;
    logic [31:0]     dtmcs;
    logic [1:0]      dmistat;
    logic            busy, busy_now, resp_xfer;
    logic            sel_idc, sel_dtmcs, sel_dmi;
    logic            dmi_go, dmi_cap_busy, dtmcs_upd, hard, clr_stat;

    assign tck_rise = tck_s[1] & ~tck_s[2];
    assign tck_fall = ~tck_s[1] & tck_s[2];
    assign tms      = tms_s[1];
    assign tdi      = tdi_s[1];

    // Bring the JTAG pins into clk and keep one extra TCK stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_s <= '0;
            tms_s <= '0;
            tdi_s <= '0;
        end else begin
            tck_s <= {tck_s[1:0], jtag_TCK};
            tms_s <= {tms_s[0], jtag_TMS};
            tdi_s <= {tdi_s[0], jtag_TDI};
        end
    end

    // IEEE 1149.1 next-state function on the synchronised TMS
    always_comb begin
        tap_next = state;
        case (state)
            TLR:     tap_next = tms ? TLR    : RTI;
            RTI:     tap_next = tms ? SEL_DR : RTI;
            SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = tms ? UPD_DR : PAU_DR;
            PAU_DR:  tap_next = tms ? EX2_DR : PAU_DR;
            EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_next = tms ? SEL_DR : RTI;
            SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = tms ? UPD_IR : PAU_IR;
            PAU_IR:  tap_next = tms ? EX2_IR : PAU_IR;
            EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_next = tms ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    end

    // Register decode, capture values and DMI/DTMCS update decisions
    always_comb begin
        sel_idc      = ir == 5'h01;
        sel_dtmcs    = ir == 5'h10;
        sel_dmi      = ir == 5'h11;
        resp_xfer    = dm_resp_valid_i & dm_resp_ready_o;
        resp_now     = resp_xfer ? dm_resp_data_i : resp_q;
        busy_now     = busy & ~resp_xfer;
        dtmcs        = {14'b0, 3'b0, IDLE_F, dmistat, ABITS_F, 4'd1};
        dmi_cap      = busy_now ? {resp_now[DW-1:2], 2'b11} : resp_now;
        dr_cap       = sel_idc ? {{(DW-32){1'b0}}, IDCODE_VALUE} :
                       sel_dtmcs ? {{(DW-32){1'b0}}, dtmcs} :
                       sel_dmi ? dmi_cap : '0;
        dr_shift     = sel_dmi ? {tdi, dr_sh[DW-1:1]} :
                       (sel_idc | sel_dtmcs) ? {{(DW-32){1'b0}}, tdi, dr_sh[31:1]} :
                       {{(DW-1){1'b0}}, tdi};
        dmi_go       = tck_rise && state == UPD_DR && sel_dmi && (dr_sh[1:0] == 2'd1 || dr_sh[1:0] == 2'd2) &&
                       !busy && dmistat == 2'b00;
        dmi_cap_busy = tck_rise && state == CAP_DR && sel_dmi && busy_now;
        dtmcs_upd    = tck_rise && state == UPD_DR && sel_dtmcs;
        hard         = dtmcs_upd & dr_sh[17];
        clr_stat     = dtmcs_upd & (dr_sh[16] | dr_sh[17]);
    end

    // TAP state, instruction and data shift registers, TDO launched on TCK fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TLR;
            ir       <= 5'h01;
            ir_sh    <= '0;
            dr_sh    <= '0;
            jtag_TDO <= 1'b0;
        end else begin
            if (tck_rise) begin
                state <= tap_next;
                ir    <= tap_next == TLR ? 5'h01 : state == UPD_IR ? ir_sh : ir;
                case (state)
                    CAP_IR:  ir_sh <= 5'b00001;
                    SH_IR:   ir_sh <= {tdi, ir_sh[4:1]};
                    CAP_DR:  dr_sh <= dr_cap;
                    SH_DR:   dr_sh <= dr_shift;
                    default: ;
                endcase
            end
            if (tck_fall)
                jtag_TDO <= state == SH_IR ? ir_sh[0] : state == SH_DR ? dr_sh[0] : 1'b0;
        end
    end

    // DMI request/response handshakes, busy tracking and sticky error status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dtm_req_valid_o <= 1'b0;
            dtm_req_data_o  <= '0;
            dm_resp_ready_o <= 1'b0;
            resp_q          <= '0;
            busy            <= 1'b0;
            dmistat         <= 2'b00;
        end else begin
            if (resp_xfer) begin
                resp_q          <= dm_resp_data_i;
                busy            <= 1'b0;
                dm_resp_ready_o <= 1'b0;
            end
            if (dtm_req_valid_o && dtm_req_ready_i) begin
                dtm_req_valid_o <= 1'b0;
                dm_resp_ready_o <= 1'b1;
            end
            if (dmi_go) begin
                dtm_req_data_o  <= dr_sh;
                dtm_req_valid_o <= 1'b1;
                busy            <= 1'b1;
            end
            if (dmi_cap_busy)
                dmistat <= 2'b11;
            if (clr_stat)
                dmistat <= 2'b00;
            if (hard) begin
                busy            <= 1'b0;
                dtm_req_valid_o <= 1'b0;
                dm_resp_ready_o <= 1'b0;
            end
        end
    end
endmodule

// File: doc/jtag_dtm_tap.md
# jtag_dtm_tap

Clock-domain JTAG responder: the target-side TAP and Debug Transport Module that answers an external JTAG host driving TCK/TMS/TDI. It oversamples TCK in the system clock domain and runs the 16-state IEEE 1149.1 TAP controller. It implements the IDCODE, DTMCS, DMI and BYPASS registers and turns completed DMI scans into a valid/ready request toward the debug module, returning the response on the next DMI capture. It sits between the SoC JTAG pins and the debug module inside the JTAG top.

## Interface
- IDCODE_VALUE, 32'h1e200a6d, value loaded into the IDCODE register on Capture-DR.
- DMI_ABITS, 6, DMI address width; DR length is DMI_ABITS+34.
- IDLE_HINT, 5, value reported in DTMCS.idle.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- jtag_TCK  in  1  host test clock, asynchronous to clk.
- jtag_TMS  in  1  test mode select, sampled on TCK rising edge.
- jtag_TDI  in  1  test data in, sampled on TCK rising edge.
- jtag_TDO  out  1  test data out, updated on TCK falling edge.
- dtm_req_valid_o  out  1  DMI request valid.
- dtm_req_ready_i  in  1  debug module accepts the request.
- dtm_req_data_o  out  DMI_ABITS+34  request {addr, data[31:0], op[1:0]}.
- dm_resp_valid_i  in  1  response valid.
- dm_resp_ready_o  out  1  DTM can take a response.
- dm_resp_data_i  in  DMI_ABITS+34  response {addr, data, op}.

## Operation
- TCK, TMS and TDI pass through 2-flop synchronisers. A third TCK flop gives tck_rise (0→1) and tck_fall (1→0) pulses of one clk each.
- On tck_rise the TAP FSM advances on the synchronised TMS through the standard 16 states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, and the IR equivalents. Shift states shift in TDI, LSB first.
- IR is 5 bits. Capture-IR loads 5'b00001. Update-IR commits the shift value. TLR forces IR=0x01 (IDCODE).
- Decode: 0x01 IDCODE (32b); 0x10 DTMCS (32b); 0x11 DMI (DMI_ABITS+34); others BYPASS (1b, captures 0).
- DTMCS capture: {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle=IDLE_HINT[2:0], dmistat[1:0], abits=DMI_ABITS, version=4'd1}.
- DTMCS update: bit16 clears sticky dmistat; bit17 also drops any pending request/response state.
- DMI capture:
  - busy (request issued, response not yet received): capture op=2'b11 and set sticky dmistat=3.
  - otherwise: capture the last response {addr, data, op}; 0 after reset.
- DMI update: op in {1,2}, not busy, sticky=0 → latch the shift register into dtm_req_data_o, assert dtm_req_valid_o, set busy. Otherwise (op 0/3, busy, or sticky set) → no request.
- Handshake: dtm_req_valid_o holds with stable data until dtm_req_valid_o && dtm_req_ready_i, then deasserts the next clk.
  - dm_resp_ready_o=1 from request acceptance until the response transfers.
  - Response transfer stores dm_resp_data_i and clears busy.
- TDO is loaded on tck_fall with the LSB of the active shift register in ShIR/ShDR, else 0.

## Timing
- Reset values: FSM=TLR, IR=0x01, jtag_TDO=0, dtm_req_valid_o=0, dtm_req_data_o=0, dm_resp_ready_o=0, busy=0, sticky=0, last response=0.
- Pin-to-FSM latency: 3 clk (2 sync + edge detect). The TCK high and low phases must each be ≥4 clk.
- dtm_req_valid_o rises 1 clk after the tck_rise that leaves UpdDR.
- A response arriving in the same clk as a DMI Capture-DR is visible in that capture (response write takes priority, capture reads the new value).
- Five tck_rise with TMS=1 reach TLR from any state. TLR does not abort an outstanding DMI transaction. Only rst_n or dmihardreset does.
- Async rst_n mid-scan returns everything to reset values immediately.

## Test plan
- Reset, then 8 TCK with TMS=1 → FSM=TLR, IR=0x01, jtag_TDO=0, dtm_req_valid_o=0.
- Scan DR after TLR (IDCODE), 32 bits of TDI=0 → TDO stream LSB-first = 0x1e200a6d.
- IR=0x10, scan 32-bit DR → TDO = 0x00005061 (idle=5, abits=6, version=1).
- IR=0x11, DMI write {6'h10, 32'h0, 2'b10} → dtm_req_data_o=40'h4000000002, valid held until ready. Response {6'h10, 32'hA5A5A5A5, 2'b00} then read scan → TDO yields 40'h4296969694.
- Hold dtm_req_ready_i=0, do a second DMI scan → captured op=3, sticky set, no new request. DTMCS write bit16 → dmistat reads 0.
- Pulse rst_n low while dtm_req_valid_o=1 → all outputs return to reset values within the same clk.
